ps2_cmd_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_sync.sv | 34 +++
 rtl/ps2_cmd_tx.sv | 193 +++++++++++++++++++
 tb/tb_ps2_cmd_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host command path.
// State encoding and default timing constants at 50 MHz.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        REQ,
        WAIT_START,
        BITS,
        ACK,
        WAIT_IDLE,
        DONE,
        FAIL
    } ps2_state_t;

    localparam int INHIBIT_CYC_DEF  = 6000;
    localparam int START_TO_CYC_DEF = 750000;
    localparam int XFER_TO_CYC_DEF  = 100000;
    localparam int MAX_RETRY_DEF    = 2;
    localparam int CNT_W            = 20;

    // Shift image sent on the wire: data LSB first, odd parity on top.
    function automatic logic [8:0] ps2_frame(input logic [7:0] d);
        return {~^d, d};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins.
// Also flags a falling edge of the synchronized clock.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_clk,
    input  logic i_dat,
    output logic o_clk,
    output logic o_dat,
    output logic o_fall
);

    logic [1:0] r_clk_sync;
    logic [1:0] r_dat_sync;
    logic       r_clk_prev;

    // Idle lines read as high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_clk};
            r_dat_sync <= {r_dat_sync[0], i_dat};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    assign o_clk  = r_clk_sync[1];
    assign o_dat  = r_dat_sync[1];
    assign o_fall = r_clk_prev & ~r_clk_sync[1];

endmodule

// File: rtl/ps2_cmd_tx.sv
// Host-to-device PS/2 command transmitter with ACK check.
// Define PS2_CMD_TX_RETRY_EN to retry failed attempts MAX_RETRY times.
module ps2_cmd_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC  = INHIBIT_CYC_DEF,
    parameter int START_TO_CYC = START_TO_CYC_DEF,
`ifdef PS2_CMD_TX_RETRY_EN
    parameter int MAX_RETRY    = MAX_RETRY_DEF,
`endif
    parameter int XFER_TO_CYC  = XFER_TO_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam logic [CNT_W-1:0] L_INH   = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] L_START = CNT_W'(START_TO_CYC);
    localparam logic [CNT_W-1:0] L_XFER  = CNT_W'(XFER_TO_CYC);

    ps2_state_t       r_state;
    logic [8:0]       r_shift;
    logic [3:0]       r_bitcnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic             r_clk_oe;
    logic             r_dat_oe;

    logic w_clk_s;
    logic w_dat_s;
    logic w_fall;
    logic w_last_try;

    ps2_line_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_clk  (ps2_clk_i),
        .i_dat  (ps2_dat_i),
        .o_clk  (w_clk_s),
        .o_dat  (w_dat_s),
        .o_fall (w_fall)
    );

`ifdef PS2_CMD_TX_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 2);
    logic [RW-1:0] r_retry;

    // Error is only reported once the retry budget is spent.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retry <= '0;
        end else if (r_state == IDLE && cmd_valid) begin
            r_retry <= '0;
        end else if (r_state == FAIL && !w_last_try) begin
            r_retry <= r_retry + RW'(1);
        end
    end

    assign w_last_try = (int'(r_retry) >= MAX_RETRY);
`else
    assign w_last_try = 1'b1;
`endif

    // Request sequence, bit shifting on device falls and ACK check.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (cmd_valid) begin
                        r_shift  <= ps2_frame(cmd_data);
                        r_bitcnt <= '0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_clk_oe <= 1'b1;
                        r_state  <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (r_cnt == L_INH) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= REQ;
                    end
                end
                REQ: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_START;
                end
                WAIT_START: begin
                    // The first device fall also shifts out data bit 0.
                    if (w_fall) begin
                        r_dat_oe <= ~r_shift[0];
                        r_bitcnt <= 4'd1;
                        r_cnt    <= '0;
                        r_state  <= BITS;
                    end else if (r_cnt >= L_START) begin
                        r_dat_oe <= 1'b0;
                        r_error  <= w_last_try;
                        r_state  <= FAIL;
                    end
                end
                BITS: begin
                    if (r_cnt >= L_XFER) begin
                        r_dat_oe <= 1'b0;
                        r_error  <= w_last_try;
                        r_state  <= FAIL;
                    end else if (w_fall) begin
                        if (r_bitcnt == 4'd9) begin
                            r_dat_oe <= 1'b0;
                            r_state  <= ACK;
                        end else begin
                            r_dat_oe <= ~r_shift[r_bitcnt];
                        end
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end
                end
                ACK: begin
                    if (r_cnt >= L_XFER || (w_fall && w_dat_s)) begin
                        r_error <= w_last_try;
                        r_state <= FAIL;
                    end else if (w_fall) begin
                        r_state <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (r_cnt >= L_XFER) begin
                        r_error <= w_last_try;
                        r_state <= FAIL;
                    end else if (w_clk_s && w_dat_s) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                FAIL: begin
                    r_error <= 1'b0;
                    r_cnt   <= '0;
                    if (w_last_try) begin
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_clk_oe <= 1'b1;
                        r_bitcnt <= '0;
                        r_state  <= INHIBIT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = r_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_cmd_tx.sv
// Bench for ps2_cmd_tx: open-drain device model, scoreboard, monitor.
// Honours PS2_CMD_TX_RETRY_EN to expect retried attempts.
module tb_ps2_cmd_tx;

    localparam int INH = 60;
    localparam int STO = 500;
    localparam int XTO = 2000;
`ifdef PS2_CMD_TX_RETRY_EN
    localparam int ATT = 3;
`else
    localparam int ATT = 1;
`endif

    typedef enum int {ACT_ACK, ACT_NAK, ACT_SILENT} act_t;
    typedef struct {
        bit         is_err;
        bit         silent;
        logic [7:0] data;
        int         att;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready, busy, done, error;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       ps2_clk_i, ps2_dat_i;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    act_t        plan[$];
    exp_t        exp_q[$];
    int          dev_h = 20;
    bit          dev_busy = 1'b0;
    int          dev_falls = 0;
    logic [10:0] dev_frame = '0;

    ps2_cmd_tx #(
        .INHIBIT_CYC  (INH),
        .START_TO_CYC (STO),
        .XFER_TO_CYC  (XTO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input bit ok,
                       input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    // Device: clocks 10 bits after each request, then ACK/NAK clock.
    initial begin : device
        act_t        a;
        logic [10:0] fr;
        int          h;
        forever begin
            @(negedge clk iff ps2_clk_oe);
            @(negedge clk iff !ps2_clk_oe);
            if (plan.size() != 0) a = plan.pop_front();
            else a = ACT_SILENT;
            if (a != ACT_SILENT) begin
                dev_busy  = 1'b1;
                dev_falls = 0;
                h = dev_h;
                repeat (10) @(negedge clk);
                fr[0] = ps2_dat_i;
                for (int i = 1; i <= 10; i++) begin
                    dev_clk_low = 1'b1;
                    dev_falls++;
                    repeat (h) @(negedge clk);
                    dev_clk_low = 1'b0;
                    repeat (h) @(negedge clk);
                    fr[i] = ps2_dat_i;
                end
                dev_frame = fr;
                if (a == ACT_ACK) dev_dat_low = 1'b1;
                repeat (2) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (h) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (h) @(negedge clk);
                dev_dat_low = 1'b0;
                dev_busy = 1'b0;
            end
        end
    end

    // Monitor: inhibit shape, pulse outcomes against the scoreboard.
    initial begin : monitor
        exp_t        e;
        int          run = 0;
        int          inh = 0;
        int          rel = 0;
        bit          prev = 1'b0;
        bit          par;
        logic [10:0] rf;
        forever begin
            @(negedge clk);
            if (reset) begin
                inh = 0;
                run = 0;
                prev = 1'b0;
            end else begin
                if (ps2_clk_oe) begin
                    if (!prev) inh++;
                    run++;
                end else if (prev) begin
                    chk("inhibit_len_then_data_low",
                        run == INH && ps2_dat_oe, run, INH);
                    run = 0;
                    rel = cyc;
                end
                prev = ps2_clk_oe;
                if (done || error) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", 1'b0, {done, error}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("outcome", {done, error} == (e.is_err ? 2'b01 : 2'b10),
                            {done, error}, e.is_err ? 1 : 2);
                        chk("attempts", inh == e.att, inh, e.att);
                        if (error)
                            chk("oe_released_on_error",
                                {ps2_clk_oe, ps2_dat_oe} == 2'b00,
                                {ps2_clk_oe, ps2_dat_oe}, 0);
                        if (e.silent) begin
                            chk("start_timeout_cycles",
                                (cyc - rel) >= STO - 1 && (cyc - rel) <= STO + 3,
                                cyc - rel, STO + 1);
                        end else begin
                            par = ($countones(e.data) % 2) == 0;
                            rf = {1'b1, par, e.data, 1'b0};
                            chk("wire_frame", dev_frame == rf, dev_frame, rf);
                        end
                    end
                    inh = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit is_err,
                        input bit silent, input int att);
        int t = 0;
        while ((!cmd_ready || dev_busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_send", cmd_ready, cmd_ready, 1);
        exp_q.push_back('{is_err: is_err, silent: silent, data: d, att: att});
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_completed"}, exp_q.size() == 0, exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        chk({nm, "_ready_after"}, cmd_ready && !busy, cmd_ready, 1);
    endtask

    initial begin : stim
        int         t;
        bit         nak;
        logic [7:0] d;
        repeat (3) @(negedge clk);
        chk("reset_state",
            {cmd_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe} == 6'b100000,
            {cmd_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe}, 6'b100000);
        reset = 1'b0;
        @(negedge clk);

        plan.push_back(ACT_ACK);
        send(8'hED, 1'b0, 1'b0, 1);
        wait_idle("ed_ack");

        send(8'hF4, 1'b1, 1'b1, ATT);
        wait_idle("f4_silent");

        repeat (ATT) plan.push_back(ACT_NAK);
        send(8'hFF, 1'b1, 1'b0, ATT);
        wait_idle("ff_nak");

        plan.push_back(ACT_ACK);
        send(8'hED, 1'b0, 1'b0, 1);
        repeat (5) @(negedge clk);
        chk("busy_not_ready", !cmd_ready && busy, cmd_ready, 0);
        cmd_data  = 8'h00;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle("busy_ignore");

        plan.push_back(ACT_ACK);
        send(8'hED, 1'b0, 1'b0, 1);
        t = 0;
        while (!(dev_busy && dev_falls >= 5) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("reached_bit5", dev_falls >= 5, dev_falls, 5);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_frame",
            {ps2_clk_oe, ps2_dat_oe, busy, done, error, cmd_ready} == 6'b000001,
            {ps2_clk_oe, ps2_dat_oe, busy, done, error, cmd_ready}, 1);
        reset = 1'b0;
        exp_q.delete();
        plan.push_back(ACT_ACK);
        send(8'hED, 1'b0, 1'b0, 1);
        wait_idle("after_reset");

        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            dev_h = int'($urandom_range(12, 30));
            nak = ($urandom_range(0, 3) == 0);
            if (nak) begin
                repeat (ATT) plan.push_back(ACT_NAK);
                send(d, 1'b1, 1'b0, ATT);
            end else begin
                plan.push_back(ACT_ACK);
                send(d, 1'b0, 1'b0, 1);
            end
            wait_idle("random");
        end

`ifdef PS2_CMD_TX_RETRY_EN
        dev_h = 20;
        plan.push_back(ACT_NAK);
        plan.push_back(ACT_NAK);
        plan.push_back(ACT_ACK);
        send(8'hED, 1'b0, 1'b0, 3);
        wait_idle("retry_third_ok");
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
